// File: rtl/par_pkg.sv
// Shared types and default sizes for the serial parity checker/generator pair.
// No logic; imported by par_chk_rx.
package par_pkg;
   localparam int DEF_DATA_W = 4;
   localparam int DEF_CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2
   } state_t;
endpackage

// File: rtl/par_calc.sv
// Even-parity XOR reduction of a data word; purely combinational, zero latency.
// No flow control; shared with the generator side.
module par_calc #(
   parameter int W = 4
) (
   input  logic [W-1:0] d,
   output logic         p
);
   assign p = ^d;
endmodule

// File: rtl/par_chk_rx.sv
// Serial frame receiver: DATA_W bits MSB-first plus even parity; result registered one edge after parity.
// din_valid low stalls the frame in place; sof mid-frame aborts and restarts; no output backpressure.
module par_chk_rx
   import par_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din,
   input  logic              din_valid,
   input  logic              sof,
   input  logic              clr_cnt,
   output logic [DATA_W-1:0] data_out,
   output logic              p_err,
   output logic              out_valid,
   output logic              abort,
   output logic [CNT_W-1:0]  err_cnt
);
   localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 2);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] sh, sh_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic              ld_out;
   logic              abort_nxt;
   logic              data_par;

   par_calc #(.W(DATA_W)) u_par_calc (
      .d (sh),
      .p (data_par)
   );

   always_comb begin
      state_nxt = state;
      sh_nxt    = sh;
      idx_nxt   = idx;
      ld_out    = 1'b0;
      abort_nxt = 1'b0;
      if (din_valid) begin
         if (sof) begin
            // New MSB lands in bit 0 and is shifted up as the remaining bits arrive.
            sh_nxt    = {{(DATA_W-1){1'b0}}, din};
            idx_nxt   = IDX_TOP;
            state_nxt = DATA;
            abort_nxt = (state != IDLE);
         end else begin
            case (state)
               DATA: begin
                  sh_nxt = {sh[DATA_W-2:0], din};
                  if (idx == '0) begin
                     state_nxt = PAR;
                  end else begin
                     idx_nxt = idx - IDX_W'(1);
                  end
               end
               PAR: begin
                  ld_out    = 1'b1;
                  state_nxt = IDLE;
               end
               default: state_nxt = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sh    <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         sh    <= sh_nxt;
         idx   <= idx_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out  <= '0;
         p_err     <= 1'b0;
         out_valid <= 1'b0;
         abort     <= 1'b0;
      end else begin
         out_valid <= ld_out;
         abort     <= abort_nxt;
         if (ld_out) begin
            data_out <= sh;
            p_err    <= data_par ^ din;
         end
      end
   end

   // Counts the registered result, so it trails out_valid by one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (clr_cnt) begin
         err_cnt <= '0;
      end else if (out_valid && p_err && (err_cnt != CNT_MAX)) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_par_chk_rx.sv
// Directed and randomized frames against a bit-counting reference model of the parity receiver.
module tb_par_chk_rx;
   localparam int DATA_W  = 4;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              din;
   logic              din_valid;
   logic              sof;
   logic              clr_cnt;
   logic [DATA_W-1:0] data_out;
   logic              p_err;
   logic              out_valid;
   logic              abort;
   logic [CNT_W-1:0]  err_cnt;

   int n_pass  = 0;
   int n_total = 0;
   int ov_seen = 0;
   int ab_seen = 0;
   int exp_err = 0;
   int ov0, ab0;

   par_chk_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .din_valid (din_valid),
      .sof       (sof),
      .clr_cnt   (clr_cnt),
      .data_out  (data_out),
      .p_err     (p_err),
      .out_valid (out_valid),
      .abort     (abort),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (out_valid) ov_seen++;
      if (abort) ab_seen++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic s, input logic b);
      sof       = s;
      din       = b;
      din_valid = 1'b1;
      tick();
      sof       = 1'b0;
      din_valid = 1'b0;
   endtask

   // Stalled cycles carry junk on din and sof to show they are ignored.
   task automatic stall(input int n);
      for (int k = 0; k < n; k++) begin
         din_valid = 1'b0;
         din       = 1'($urandom_range(0, 1));
         sof       = 1'($urandom_range(0, 1));
         tick();
      end
      sof = 1'b0;
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] bits, input logic par, input int gap);
      int ones;
      logic exp_pe;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         send_bit(i == DATA_W - 1, bits[i]);
         if (gap > 0) stall(gap);
      end
      send_bit(1'b0, par);
      ones   = $countones(bits) + int'(par);
      exp_pe = (ones % 2) != 0;
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("data_out", 32'(data_out), 32'(bits));
      chk("p_err", 32'(p_err), 32'(exp_pe));
      if (exp_pe) exp_err = (exp_err < CNT_MAX) ? exp_err + 1 : CNT_MAX;
   endtask

   initial begin
      logic [DATA_W-1:0] rb;
      logic              rp;
      rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; sof = 1'b0; clr_cnt = 1'b0;
      tick(); tick();
      chk("rst data_out", 32'(data_out), 32'd0);
      chk("rst p_err", 32'(p_err), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst abort", 32'(abort), 32'd0);
      chk("rst err_cnt", 32'(err_cnt), 32'd0);
      #2 rst_n = 1'b1;
      tick();

      // good frame, continuous valid
      send_frame(4'b1011, 1'b1, 0);
      tick();
      chk("ov pulse width", 32'(out_valid), 32'd0);
      tick();
      chk("err_cnt good", 32'(err_cnt), 32'(exp_err));

      // errored frame, then clear racing a second error
      send_frame(4'b1011, 1'b0, 0);
      tick(); tick();
      chk("err_cnt one", 32'(err_cnt), 32'(exp_err));
      send_frame(4'b1011, 1'b0, 0);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      exp_err = 0;
      tick();
      chk("clr wins", 32'(err_cnt), 32'(exp_err));

      // stalls between every bit
      ov0 = ov_seen;
      send_frame(4'b0110, 1'b0, 3);
      tick(); tick();
      chk("stall ov count", 32'(ov_seen - ov0), 32'd1);

      // abort mid-frame then a clean frame
      ov0 = ov_seen; ab0 = ab_seen;
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      send_frame(4'b1111, 1'b0, 0);
      tick(); tick();
      chk("abort count", 32'(ab_seen - ab0), 32'd1);
      chk("abort ov count", 32'(ov_seen - ov0), 32'd1);

      // random frames with random stalls
      for (int f = 0; f < 24; f++) begin
         rb = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
         rp = 1'($urandom_range(0, 1));
         send_frame(rb, rp, int'($urandom_range(0, 2)));
         if ($urandom_range(0, 3) == 0) tick();
      end
      tick(); tick();
      chk("err_cnt random", 32'(err_cnt), 32'(exp_err));

      // back-to-back errored frames into saturation
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      exp_err = 0;
      ov0 = ov_seen;
      for (int f = 0; f < 260; f++) begin
         rb = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
         rp = (($countones(rb) % 2) == 0);
         send_frame(rb, rp, 0);
      end
      tick(); tick();
      chk("err_cnt sat", 32'(err_cnt), 32'(exp_err));
      chk("b2b ov count", 32'(ov_seen - ov0), 32'd260);
      tick(); tick(); tick();
      chk("err_cnt held", 32'(err_cnt), 32'd255);

      // reset in the middle of a frame
      ov0 = ov_seen; ab0 = ab_seen;
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      chk("mid rst data_out", 32'(data_out), 32'd0);
      chk("mid rst p_err", 32'(p_err), 32'd0);
      chk("mid rst err_cnt", 32'(err_cnt), 32'd0);
      exp_err = 0;
      tick();
      chk("mid rst out_valid", 32'(out_valid), 32'd0);
      chk("mid rst abort", 32'(abort), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      send_frame(4'b1000, 1'b1, 0);
      tick(); tick();
      chk("post rst ov count", 32'(ov_seen - ov0), 32'd1);
      chk("post rst abort count", 32'(ab_seen - ab0), 32'd0);
      chk("post rst err_cnt", 32'(err_cnt), 32'(exp_err));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
